// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 constants, controller state encoding, rcon
//               lookup and GF(2^8) S-box helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    localparam int c_byte_w = 8;
    localparam int c_col_w  = 32;
    localparam int c_nbytes = 16;
    localparam int c_ncols  = 4;
    localparam int c_nrows  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] v;
        case (rnd)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Inverse as a^254 (repeated squaring); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_step
// Description : Combinational AES-128 round-key expansion step
//               (previous round key + rcon -> next round key).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] i_rk,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_rk
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot, w_sub, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0  = i_rk[127:96];
    assign w_w1  = i_rk[95:64];
    assign w_w2  = i_rk[63:32];
    assign w_w3  = i_rk[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[31-8*i -: 8]),
                .o_byte (w_sub[31-8*i -: 8])
            );
        end
    endgenerate

    assign w_t  = w_sub ^ {i_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;
    assign o_rk = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes_mix_columns.sv
`default_nettype none
// ============================================================================
// Module      : aes_mix_columns
// Description : Combinational AES MixColumns over the full 128-bit state.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);

    genvar c;
    generate
        for (c = 0; c < c_ncols; c++) begin : g_col
            logic [7:0] w_a0, w_a1, w_a2, w_a3;
            assign w_a0 = i_state[127-32*c -: 8];
            assign w_a1 = i_state[119-32*c -: 8];
            assign w_a2 = i_state[111-32*c -: 8];
            assign w_a3 = i_state[103-32*c -: 8];

            assign o_state[127-32*c -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
            assign o_state[119-32*c -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
            assign o_state[111-32*c -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
            assign o_state[103-32*c -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Single combinational AES forward S-box.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = sbox_f(i_byte);

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl
// Description : Iterative AES-128 encryption controller, one round per clock,
//               on-the-fly key expansion. Optional AES_ROUND_CTRL_PERF_EN
//               adds a completed-block counter output blk_count.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     plaintext,
    input  logic [KEY_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     ciphertext,
    output logic             busy
`ifdef AES_ROUND_CTRL_PERF_EN
    ,
    output logic [31:0]      blk_count
`endif
);

    import aes_pkg::*;

    state_t       r_fsm, w_fsm_nxt;
    logic [127:0] r_state, w_state_nxt;
    logic [127:0] r_rk, w_rk_nxt;
    logic [3:0]   r_rnd, w_rnd_nxt;

    logic [127:0] w_sb, w_sr, w_mc, w_rk_step;
    logic [7:0]   w_rcon;
    logic         w_final;

    assign w_rcon  = rcon(r_rnd);
    assign w_final = (r_rnd == 4'(NR));

    aes_key_step u_key_step (
        .i_rk   (r_rk),
        .i_rcon (w_rcon),
        .o_rk   (w_rk_step)
    );

    genvar i, r, c;
    generate
        for (i = 0; i < c_nbytes; i++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (r_state[127-8*i -: 8]),
                .o_byte (w_sb[127-8*i -: 8])
            );
        end
        // Row r of column c takes row r of column (c + r) mod 4.
        for (r = 0; r < c_nrows; r++) begin : g_sr_row
            for (c = 0; c < c_ncols; c++) begin : g_sr_col
                assign w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    endgenerate

    aes_mix_columns u_mix (
        .i_state (w_sr),
        .o_state (w_mc)
    );

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_rk_nxt    = r_rk;
        w_rnd_nxt   = r_rnd;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = plaintext ^ key;
                    w_rk_nxt    = key;
                    w_rnd_nxt   = 4'd1;
                    w_fsm_nxt   = ROUND;
                end
            end
            ROUND: begin
                busy        = 1'b1;
                w_state_nxt = (w_final ? w_sr : w_mc) ^ w_rk_step;
                w_rk_nxt    = w_rk_step;
                if (w_final) begin
                    w_fsm_nxt = DONE;
                end else begin
                    w_rnd_nxt = r_rnd + 4'd1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_nxt = plaintext ^ key;
                        w_rk_nxt    = key;
                        w_rnd_nxt   = 4'd1;
                        w_fsm_nxt   = ROUND;
                    end else begin
                        w_rnd_nxt = 4'd0;
                        w_fsm_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_rnd_nxt = 4'd0;
                w_fsm_nxt = IDLE;
            end
        endcase
        // Handshake outputs are held low while reset is being applied.
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_rnd   <= 4'd0;
            r_state <= 128'd0;
            r_rk    <= 128'd0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_rnd   <= w_rnd_nxt;
            r_state <= w_state_nxt;
            r_rk    <= w_rk_nxt;
        end
    end

    assign ciphertext = r_state;

`ifdef AES_ROUND_CTRL_PERF_EN
    logic [31:0] r_blk_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_count <= 32'd0;
        end else if (out_valid && out_ready) begin
            r_blk_count <= r_blk_count + 32'd1;
        end
    end

    assign blk_count = r_blk_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Directed self-checking bench for aes_round_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
`ifdef AES_ROUND_CTRL_PERF_EN
    logic [31:0]  blk_count;
`endif

    localparam logic [127:0] c_pt_b  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_key_b = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_pt_c  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_key_c = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_ct_c  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int checks = 0;
    int errors = 0;

    aes_round_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
`ifdef AES_ROUND_CTRL_PERF_EN
        ,
        .blk_count  (blk_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 40);
    endtask

    // Accept one block from IDLE, check latency and result, then release it.
    task automatic run_block(input string tag, input logic [127:0] pt,
                             input logic [127:0] k, input logic [127:0] exp);
        int n;
        in_valid  = 1'b1;
        plaintext = pt;
        key       = k;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        chk({tag, "_inrdy_round"}, 128'(in_ready), 128'(0));
        wait_out(n);
        chk({tag, "_latency"}, 128'(n), 128'(10));
        chk({tag, "_ct"}, ciphertext, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_released"}, 128'(out_valid), 128'(0));
        chk({tag, "_idle_rdy"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        int n;
        int bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key       = '0;

        tick();
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ct", ciphertext, 128'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 128'(in_ready), 128'(1));
        chk("idle_busy", 128'(busy), 128'(0));
`ifdef AES_ROUND_CTRL_PERF_EN
        chk("perf_rst", 128'(blk_count), 128'(0));
`endif

        // FIPS-197 Appendix B
        run_block("appb", c_pt_b, c_key_b, c_ct_b);

        // Appendix C.1 with noise on the inputs during the rounds
        in_valid  = 1'b1;
        plaintext = c_pt_c;
        key       = c_key_c;
        tick();
        n = 0;
        do begin
            in_valid  = 1'b1;
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'b1;
            tick();
            n++;
        end while (!out_valid && n < 40);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("appc_latency", 128'(n), 128'(10));
        chk("appc_ct", ciphertext, c_ct_c);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure: App B held in DONE while App C.1 waits at the input
        in_valid  = 1'b1;
        plaintext = c_pt_b;
        key       = c_key_b;
        tick();
        plaintext = c_pt_c;
        key       = c_key_c;
        wait_out(n);
        chk("bp_latency", 128'(n), 128'(10));
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ciphertext !== c_ct_b || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        chk("bp_hold", 128'(bad), 128'(0));
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_accept_busy", 128'(busy), 128'(1));
        chk("bp_accept_ov", 128'(out_valid), 128'(0));
`ifdef AES_ROUND_CTRL_PERF_EN
        chk("perf_three", 128'(blk_count), 128'(3));
`endif
        wait_out(n);
        chk("bp2_latency", 128'(n), 128'(10));
        chk("bp2_ct", ciphertext, c_ct_c);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back with in_valid and out_ready held high
        in_valid  = 1'b1;
        out_ready = 1'b1;
        plaintext = c_pt_b;
        key       = c_key_b;
        tick();
        plaintext = c_pt_c;
        key       = c_key_c;
        wait_out(n);
        chk("b2b1_latency", 128'(n), 128'(10));
        chk("b2b1_ct", ciphertext, c_ct_b);
        chk("b2b1_in_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        chk("b2b2_busy", 128'(busy), 128'(1));
        chk("b2b2_ov", 128'(out_valid), 128'(0));
        wait_out(n);
        chk("b2b2_latency", 128'(n), 128'(10));
        chk("b2b2_ct", ciphertext, c_ct_c);
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", 128'(in_ready), 128'(1));

        // Reset at round 5 discards the block
        in_valid  = 1'b1;
        plaintext = c_pt_b;
        key       = c_key_b;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_ov", 128'(out_valid), 128'(0));
`ifdef AES_ROUND_CTRL_PERF_EN
        chk("perf_clear", 128'(blk_count), 128'(0));
`endif
        rst = 1'b0;
        #1;
        chk("mid_rst_idle", 128'(in_ready), 128'(1));
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        chk("mid_rst_no_ov", 128'(bad), 128'(0));
        run_block("after_rst", c_pt_b, c_key_b, c_ct_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
